// File: rtl/integer_writeback_if.sv
// Bundle of every non-clock signal between the integer writeback stage and
// its neighbours: the issue side (decode + integer_ops flags and results),
// the register-file write port, the operand-forwarding lookup and the flag
// register outputs.
//
//   slave  : the writeback stage itself
//   master : whoever drives issue/results and consumes writes (decode/CPU)
//
// Signals
//   issue_en/issue_ready/issue_wr/issue_addr/issue_set_flags : issue handshake
//   alu_cf/alu_of/alu_zf       : integer_ops flags, valid in the issue cycle
//   dout_select, dout1..dout3  : integer_ops results, valid the cycle after issue
//   wr_valid/wr_ready/wr_addr/wr_data : register-file write port
//   rd_addr -> fwd_hit/fwd_data       : forwarding lookup
//   cf/of/zf, err_sel                 : flag register, sticky select error
interface integer_writeback_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              issue_en;
  logic              issue_ready;
  logic              issue_wr;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_set_flags;
  logic              alu_cf;
  logic              alu_of;
  logic              alu_zf;
  logic [1:0]        dout_select;
  logic [WIDTH-1:0]  dout1;
  logic [WIDTH-1:0]  dout2;
  logic [WIDTH-1:0]  dout3;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  logic              cf;
  logic              of;
  logic              zf;
  logic              err_sel;

  modport slave (
    input  issue_en, issue_wr, issue_addr, issue_set_flags,
    input  alu_cf, alu_of, alu_zf,
    input  dout_select, dout1, dout2, dout3,
    input  wr_ready, rd_addr,
    output issue_ready, wr_valid, wr_addr, wr_data,
    output fwd_hit, fwd_data, cf, of, zf, err_sel
  );

  modport master (
    output issue_en, issue_wr, issue_addr, issue_set_flags,
    output alu_cf, alu_of, alu_zf,
    output dout_select, dout1, dout2, dout3,
    output wr_ready, rd_addr,
    input  issue_ready, wr_valid, wr_addr, wr_data,
    input  fwd_hit, fwd_data, cf, of, zf, err_sel
  );
endinterface

// File: rtl/integer_writeback.sv
// Integer writeback stage of the sha256crypt CPU.
//
// Follows each accepted integer op through the one-cycle latency of
// integer_ops, picks the result selected by dout_select, and queues the
// register write in a two-entry in-order buffer drained through a
// valid/ready write port. Also holds the CF/OF/ZF flag register (updated at
// issue time) and forwards the youngest pending result for rd_addr.
//
// Ports
//   CLK    : clock
//   RST_N  : synchronous reset, active-low
//   bus    : integer_writeback_if.slave (issue, results, write port,
//            forwarding, flags, err_sel)
module integer_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  integer_writeback_if.slave  bus
);

  // Result selection; select code 0 is illegal for a writing op and yields zero.
  function automatic logic [WIDTH-1:0] select_result(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] d1,
    input logic [WIDTH-1:0] d2,
    input logic [WIDTH-1:0] d3
  );
    case (sel)
      2'd1:    return d1;
      2'd2:    return d2;
      2'd3:    return d3;
      default: return '0;
    endcase
  endfunction

  // ---- issue stage (p0): one in-flight writing op awaiting its result ----
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [WIDTH-1:0]  result_p0;

  // ---- buffer stage (p1): two-entry in-order write queue ----
  logic [ADDR_W-1:0] fifo_addr_p1 [2];
  logic [WIDTH-1:0]  fifo_data_p1 [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic cf_q, of_q, zf_q, err_q;
  logic accept, push, pop;
  logic tail_idx;
  logic issue_ready_w;
  logic wr_valid_w;

  // Admission only looks at registered occupancy so that issue_ready has no
  // combinational dependence on wr_ready. An accepted op occupies the slot now
  // and a queue entry next cycle, so at most one of the two places may be taken.
  always_comb begin
    issue_ready_w = 1'b0;
    if (count == 2'd0)
      issue_ready_w = 1'b1;
    else if (count == 2'd1 && !vld_p0)
      issue_ready_w = 1'b1;
  end

  assign accept     = bus.issue_en & issue_ready_w;
  assign result_p0  = select_result(bus.dout_select, bus.dout1, bus.dout2, bus.dout3);
  assign wr_valid_w = (count != 2'd0);
  assign push       = vld_p0;
  assign pop        = wr_valid_w & bus.wr_ready;
  assign tail_idx   = ~wr_ptr;

  // Control state: the only registers that reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_p0 <= 1'b0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cf_q   <= 1'b0;
      of_q   <= 1'b0;
      zf_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_p0 <= accept & bus.issue_wr;

      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // Flags belong to the issue cycle, not to writeback.
      if (accept && bus.issue_set_flags) begin
        cf_q <= bus.alu_cf;
        of_q <= bus.alu_of;
        zf_q <= bus.alu_zf;
      end

      if (vld_p0 && bus.dout_select == 2'd0)
        err_q <= 1'b1;
    end
  end

  // Datapath registers: contents are only observed when qualified by
  // vld_p0 or count, so they are not reset.
  always_ff @(posedge CLK) begin
    if (accept && bus.issue_wr)
      addr_p0 <= bus.issue_addr;
    if (push) begin
      fifo_addr_p1[wr_ptr] <= addr_p0;
      fifo_data_p1[wr_ptr] <= result_p0;
    end
  end

  // ---- write port (p1 head) ----
  always_comb begin
    bus.wr_valid = wr_valid_w;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    if (wr_valid_w) begin
      bus.wr_addr = fifo_addr_p1[rd_ptr];
      bus.wr_data = fifo_data_p1[rd_ptr];
    end
  end

  // Forwarding: later assignments override earlier ones, so the youngest
  // match wins (in-flight slot > queue tail > queue head). With one entry
  // queued head and tail are the same slot, so the head is only checked
  // separately when two entries are present.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (count == 2'd2 && fifo_addr_p1[rd_ptr] == bus.rd_addr) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = fifo_data_p1[rd_ptr];
    end
    if (count != 2'd0 && fifo_addr_p1[tail_idx] == bus.rd_addr) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = fifo_data_p1[tail_idx];
    end
    if (vld_p0 && addr_p0 == bus.rd_addr) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = result_p0;
    end
  end

  assign bus.issue_ready = issue_ready_w;
  assign bus.cf          = cf_q;
  assign bus.of          = of_q;
  assign bus.zf          = zf_q;
  assign bus.err_sel     = err_q;

endmodule
